// File: rtl/decod_pkg.sv
// Shared constants and the reference decode function for the binary-to-one-hot decoder.
package decod_pkg;

  // Default code width and the matching number of output lines.
  localparam int DEF_IN_W  = 3;
  localparam int DEF_OUT_W = 2 ** DEF_IN_W;

  // Active-high one-hot decode of a default-width code: bit 'code' set, all others clear.
  function automatic logic [DEF_OUT_W-1:0] onehot_of(input logic [DEF_IN_W-1:0] code);
    logic [DEF_OUT_W-1:0] w_hot;
    w_hot       = '0;
    w_hot[code] = 1'b1;
    return w_hot;
  endfunction

endpackage : decod_pkg

// File: rtl/decod_core.sv
// Purely combinational decoder: code + enable -> one-hot lines with polarity applied.
module decod_core
  import decod_pkg::*;
#(
  parameter  int IN_W       = DEF_IN_W,
  parameter  bit ACTIVE_LOW = 1'b0,
  localparam int OUT_W      = 2 ** IN_W
) (
  input  logic [IN_W-1:0]  i_code,
  input  logic             i_en,
  output logic [OUT_W-1:0] o_dec
);

  logic [OUT_W-1:0] w_hot;
  logic [OUT_W-1:0] w_gated;

  // The default width reuses the shared package function; other widths decode with a compare loop.
  if (IN_W == DEF_IN_W) begin : g_pkg_decode
    assign w_hot = onehot_of(i_code);
  end else begin : g_loop_decode
    // Raw active-high one-hot decode for non-default widths.
    always_comb begin
      // NOTE: every bit gets a default before the loop, so no path leaves w_hot unassigned and no latch is inferred.
      w_hot = '0;
      for (int i = 0; i < OUT_W; i++) begin
        w_hot[i] = (i_code == IN_W'(i));
      end
    end
  end

  // Gate with enable; when disabled the decode (even of an unknown code) is never selected.
  always_comb begin
    w_gated = '0;
    if (i_en) begin
      w_gated = w_hot;
    end
  end

  // Apply output polarity: active-low flips both the selected line and the idle lines.
  assign o_dec = ACTIVE_LOW ? ~w_gated : w_gated;

endmodule : decod_core

// File: rtl/decod_3to8.sv
// Registered binary-to-one-hot decoder with enable; one clock of latency, glitch-free strobes.
module decod_3to8
  import decod_pkg::*;
#(
  parameter  int IN_W       = DEF_IN_W,
  parameter  bit ACTIVE_LOW = 1'b0,
  localparam int OUT_W      = 2 ** IN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in,
  input  logic             en,
  output logic [OUT_W-1:0] d,
  output logic             valid
);

  // Pattern driven when no line is selected (reset or disabled).
  localparam logic [OUT_W-1:0] INACTIVE = ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  logic [OUT_W-1:0] w_dec;
  logic [OUT_W-1:0] r_d;
  logic             r_valid;

  decod_core #(
    .IN_W       (IN_W),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_core (
    .i_code (in),
    .i_en   (en),
    .o_dec  (w_dec)
  );

  // Register the decode and its valid flag; synchronous reset wins over en and in.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values, avoiding order-dependent races.
    if (rst) begin
      r_d     <= INACTIVE;
      r_valid <= 1'b0;
    end else begin
      r_d     <= w_dec;
      r_valid <= en;
    end
  end

  assign d     = r_d;
  assign valid = r_valid;

endmodule : decod_3to8

// File: tb/tb_decod_3to8.sv
// Directed self-checking bench for decod_3to8: active-high and active-low instances share stimulus.
module tb_decod_3to8;

  logic       clk;
  logic       rst;
  logic [2:0] in;
  logic       en;
  logic [7:0] d_hi;
  logic       valid_hi;
  logic [7:0] d_lo;
  logic       valid_lo;

  int n_vec;
  int n_err;

  decod_3to8 #(.IN_W(3), .ACTIVE_LOW(1'b0)) dut_hi (
    .clk   (clk),
    .rst   (rst),
    .in    (in),
    .en    (en),
    .d     (d_hi),
    .valid (valid_hi)
  );

  decod_3to8 #(.IN_W(3), .ACTIVE_LOW(1'b1)) dut_lo (
    .clk   (clk),
    .rst   (rst),
    .in    (in),
    .en    (en),
    .d     (d_lo),
    .valid (valid_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; in = 3'b101;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_vec++;
      if (d_hi !== 8'h00 || valid_hi !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: d=%h valid=%b, want d=00 valid=0", c, d_hi, valid_hi);
      end
      n_vec++;
      if (d_lo !== 8'hFF || valid_lo !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold_al[%0d]: d=%h valid=%b, want d=ff valid=0", c, d_lo, valid_lo);
      end
    end
    rst = 1'b0;
    tick();
    n_vec++;
    if (d_hi !== 8'h20 || valid_hi !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release: d=%h valid=%b, want d=20 valid=1", d_hi, valid_hi);
    end
  endtask

  task automatic test_enabled_sweep();
    logic [7:0] exp_d [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in = 3'(i);
      tick();
      n_vec++;
      if (d_hi !== exp_d[i] || valid_hi !== 1'b1) begin
        n_err++;
        $display("FAIL en_sweep in=%0d: d=%h valid=%b, want d=%h valid=1", i, d_hi, valid_hi, exp_d[i]);
      end
    end
  endtask

  task automatic test_disabled_sweep();
    en = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in = (i == 8) ? 3'bxxx : 3'(i);
      tick();
      n_vec++;
      if (d_hi !== 8'h00 || valid_hi !== 1'b0) begin
        n_err++;
        $display("FAIL dis_sweep step=%0d: d=%h valid=%b, want d=00 valid=0", i, d_hi, valid_hi);
      end
    end
  endtask

  task automatic test_reset_mid();
    en = 1'b1; in = 3'b110;
    tick();
    n_vec++;
    if (d_hi !== 8'h40 || valid_hi !== 1'b1) begin
      n_err++;
      $display("FAIL mid_pre: d=%h valid=%b, want d=40 valid=1", d_hi, valid_hi);
    end
    rst = 1'b1;
    tick();
    n_vec++;
    if (d_hi !== 8'h00 || valid_hi !== 1'b0) begin
      n_err++;
      $display("FAIL mid_rst: d=%h valid=%b, want d=00 valid=0", d_hi, valid_hi);
    end
    rst = 1'b0;
    tick();
    n_vec++;
    if (d_hi !== 8'h40 || valid_hi !== 1'b1) begin
      n_err++;
      $display("FAIL mid_post: d=%h valid=%b, want d=40 valid=1", d_hi, valid_hi);
    end
  endtask

  task automatic test_back_to_back();
    logic       v_en  [3] = '{1'b1, 1'b0, 1'b1};
    logic [2:0] v_in  [3] = '{3'd2, 3'd7, 3'd7};
    logic [7:0] v_exp [3] = '{8'h04, 8'h00, 8'h80};
    for (int i = 0; i < 3; i++) begin
      en = v_en[i]; in = v_in[i];
      tick();
      n_vec++;
      if (d_hi !== v_exp[i] || valid_hi !== v_en[i]) begin
        n_err++;
        $display("FAIL toggle[%0d]: d=%h valid=%b, want d=%h valid=%b", i, d_hi, valid_hi, v_exp[i], v_en[i]);
      end
    end
  endtask

  task automatic test_active_low();
    en = 1'b1; in = 3'b011;
    tick();
    n_vec++;
    if (d_lo !== 8'hF7 || valid_lo !== 1'b1) begin
      n_err++;
      $display("FAIL al_sel: d=%h valid=%b, want d=f7 valid=1", d_lo, valid_lo);
    end
    en = 1'b0;
    tick();
    n_vec++;
    if (d_lo !== 8'hFF || valid_lo !== 1'b0) begin
      n_err++;
      $display("FAIL al_dis: d=%h valid=%b, want d=ff valid=0", d_lo, valid_lo);
    end
    en = 1'b1; in = 3'b000;
    tick();
    n_vec++;
    if (d_lo !== 8'hFE) begin
      n_err++;
      $display("FAIL al_in0: d=%h, want d=fe", d_lo);
    end
    rst = 1'b1;
    tick();
    n_vec++;
    if (d_lo !== 8'hFF || valid_lo !== 1'b0) begin
      n_err++;
      $display("FAIL al_rst: d=%h valid=%b, want d=ff valid=0", d_lo, valid_lo);
    end
    rst = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; en = 1'b0; in = 3'b000;
    @(negedge clk);
    test_reset();
    test_enabled_sweep();
    test_disabled_sweep();
    test_reset_mid();
    test_back_to_back();
    test_active_low();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard bound on run time in case the clock or stimulus stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_decod_3to8

// File: doc/decod_3to8.md
Name: decod_3to8

Overview:
- Registered binary-to-one-hot decoder with enable: an IN_W-bit code selects one of 2**IN_W output lines.
- Default configuration is 3-to-8.
- Used wherever a select/address code must drive individual strobe or chip-select lines.
- Output is registered (one-cycle latency) so downstream logic sees glitch-free one-hot strobes.

Parameters:
- IN_W, 3, width of input code; output width is OUT_W = 2**IN_W (derived localparam, not overridable).
- ACTIVE_LOW, 0, 0 = selected line driven 1 with others 0; 1 = selected line driven 0 with others 1.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in  input  IN_W  binary code selecting the output line.
- en  input  1  decode enable; 0 forces all lines inactive.
- d  output  OUT_W  registered one-hot decode result (polarity per ACTIVE_LOW).
- valid  output  1  registered copy of en, aligned with d.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Inactive pattern: all zeros when ACTIVE_LOW=0, all ones when ACTIVE_LOW=1.
- Reset (rst=1 at rising edge): d takes the inactive pattern and valid=0.
  - Reset has priority over en and in.
  - Reset asserted mid-operation clears d on that same edge.
  - The first post-reset decode appears one edge after rst deasserts with en=1.
- Normal edge, rst=0, en=1: d[i] is active for i == in (unsigned) and inactive for every other i; valid=1.
- Normal edge, rst=0, en=0: d takes the inactive pattern regardless of in; valid=0.
- Latency is exactly 1 clock: the value sampled on en/in at edge N is visible on d/valid after edge N, until edge N+1.
- Output invariant: for ACTIVE_LOW=0, d has exactly one bit set when valid=1 and no bits set when valid=0 (mirrored for ACTIVE_LOW=1).
- Boundaries:
  - in=0 drives d[0]; in=OUT_W-1 drives the MSB line.
  - There are no out-of-range codes.
- X/Z on in while en=0 must not propagate to d; the registered value is the inactive pattern.
- Simultaneous en and in changes take effect together at the next edge; no intermediate value is ever registered.
- No combinational path exists from inputs to outputs.

Decomposition:
- Shared package decod_pkg holds:
  - the default IN_W constant;
  - a function onehot_of(code) returning the OUT_W-bit decode (used by RTL and by the bench model).
- One natural sub-module: decod_core, the purely combinational decoder (in, en -> raw one-hot, polarity applied).
- The top module registers the decod_core output plus valid, and applies reset.

Test Plan:
- Reset: rst=1 for 2 cycles with en=1, in=3'b101 -> d=8'h00, valid=0 throughout; after release, next edge gives d=8'h20, valid=1.
- Enabled sweep (en=1): in=0..7, one per cycle -> after each edge d = 8'h01, 02, 04, 08, 10, 20, 40, 80 in order; valid=1.
- Disabled sweep (en=0): in=0..7 -> d=8'h00 and valid=0 on every cycle.
- Reset mid-operation: en=1, in=3'b110 gives d=8'h40; assert rst for one edge -> d=8'h00; deassert -> d=8'h40 one edge later.
- Enable toggle with simultaneous code change: (en=1,in=2) then (en=0,in=7) then (en=1,in=7) -> d = 8'h04, 8'h00, 8'h80 on successive edges.
- ACTIVE_LOW=1 variant, en=1, in=3'b011 -> d=8'hF7; en=0 or reset -> d=8'hFF.
